// File: rtl/chip8_pkg.sv
// Shared CHIP-8 display constants and scan-out state type.
// Build option: CHIP8_SCANOUT_SCALE2X_EN selects the 128x64 pixel-doubled
// scan geometry (1024 bytes per frame) instead of native 64x32 (256 bytes).
package chip8_pkg;

    localparam int CHIP8_COLS        = 64;
    localparam int CHIP8_ROWS        = 32;
    localparam int CHIP8_FB_BITS     = 2048;
    localparam int CHIP8_PAGES       = 4;
    localparam int CHIP8_FRAME_BYTES = 256;

    localparam int CHIP8_S2X_COLS        = 128;
    localparam int CHIP8_S2X_ROWS        = 64;
    localparam int CHIP8_S2X_PAGES       = 8;
    localparam int CHIP8_S2X_FRAME_BYTES = 1024;

`ifdef CHIP8_SCANOUT_SCALE2X_EN
    localparam int SCAN_FRAME_BYTES = CHIP8_S2X_FRAME_BYTES;
    localparam int SCAN_IDX_W       = 10;
`else
    localparam int SCAN_FRAME_BYTES = CHIP8_FRAME_BYTES;
    localparam int SCAN_IDX_W       = 8;
`endif

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } scan_state_t;

endpackage

// File: rtl/chip8_scan_byte_mux.sv
// Combinational gather of one panel column byte from the frame snapshot.
// Byte index is page-major (page in the high bits, column in the low bits).
// Build option: CHIP8_SCANOUT_SCALE2X_EN maps the 128x64 doubled panel back
// onto the 64x32 source by dropping the low bit of both column and row.
module chip8_scan_byte_mux
    import chip8_pkg::*;
(
    input  logic [CHIP8_FB_BITS-1:0] snapshot,
    input  logic [SCAN_IDX_W-1:0]    byte_idx,
    output logic [7:0]               byte_data
);

`ifdef CHIP8_SCANOUT_SCALE2X_EN
    logic [2:0] page;
    logic [5:0] src_x;
    logic       unused_col_lsb;

    assign page           = byte_idx[9:7];
    assign src_x          = byte_idx[6:1];
    assign unused_col_lsb = byte_idx[0];

    // Source row = (page*8+k)>>1 = {page, k[2:1]}; each source row feeds two panel bits.
    for (genvar k = 0; k < 8; k++) begin : g_bit
        localparam logic [2:0] K = 3'(k);
        assign byte_data[k] = snapshot[{page, K[2:1], src_x}];
    end
`else
    logic [1:0] page;
    logic [5:0] col;

    assign page = byte_idx[7:6];
    assign col  = byte_idx[5:0];

    // Pixel index = (page*8+k)*64 + col, which is the concatenation {page, k, col}.
    for (genvar k = 0; k < 8; k++) begin : g_bit
        localparam logic [2:0] K = 3'(k);
        assign byte_data[k] = snapshot[{page, K, col}];
    end
`endif

endmodule

// File: rtl/chip8_display_scanout.sv
// CHIP-8 framebuffer scan-out: snapshots the live bitmap on a frame request
// and streams it as panel column bytes over valid/ready, flagging the final
// byte and pulsing frame_done after it is accepted. One extra request may be
// queued during a frame so frames can run back to back.
// Build option: CHIP8_SCANOUT_SCALE2X_EN (pixel-doubled 128x64 output).
module chip8_display_scanout
    import chip8_pkg::*;
#(
    parameter int REFRESH_CYCLES = 0,
    parameter int CNT_W          = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CHIP8_FB_BITS-1:0] display,
    input  logic                     frame_req,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     frame_done
);

    localparam logic [SCAN_IDX_W-1:0] LAST_IDX = SCAN_IDX_W'(SCAN_FRAME_BYTES - 1);

    scan_state_t               state, next_state;
    logic [CHIP8_FB_BITS-1:0]  snapshot;
    logic [SCAN_IDX_W-1:0]     byte_idx;
    logic                      pending, pending_next;
    logic                      done_q;
    logic                      load_frame, advance;
    logic                      auto_tick, req, handshake, final_hs;
    logic [7:0]                mux_byte;

    generate
        if (REFRESH_CYCLES > 0) begin : g_refresh
            logic [CNT_W-1:0] refresh_cnt;
            logic             wrap;

            assign wrap      = (refresh_cnt == CNT_W'(REFRESH_CYCLES - 1));
            assign auto_tick = wrap;

            // Free-running refresh period counter, independent of the FSM.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)    refresh_cnt <= '0;
                else if (wrap) refresh_cnt <= '0;
                else           refresh_cnt <= refresh_cnt + CNT_W'(1);
            end
        end else begin : g_no_refresh
            assign auto_tick = 1'b0;
        end
    endgenerate

    assign req       = frame_req | auto_tick;
    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign handshake = out_valid & out_ready;
    assign final_hs  = handshake & (byte_idx == LAST_IDX);
    assign out_last  = out_valid & (byte_idx == LAST_IDX);
    assign out_data  = out_valid ? mux_byte : 8'h00;
    assign frame_done = done_q;

    chip8_scan_byte_mux u_byte_mux (
        .snapshot  (snapshot),
        .byte_idx  (byte_idx),
        .byte_data (mux_byte)
    );

    // Next-state and control decode: start, advance, restart from pending request.
    always_comb begin
        next_state   = state;
        load_frame   = 1'b0;
        advance      = 1'b0;
        pending_next = pending;
        unique case (state)
            IDLE: begin
                if (req) begin
                    load_frame = 1'b1;
                    next_state = STREAM;
                end
            end
            STREAM: begin
                if (final_hs) begin
                    // A request arriving on the final edge is treated as already queued.
                    pending_next = 1'b0;
                    if (pending || req) load_frame = 1'b1;
                    else                next_state = IDLE;
                end else begin
                    if (handshake) advance = 1'b1;
                    if (req)       pending_next = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State, snapshot, byte counter, queued request and completion pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            snapshot <= '0;
            byte_idx <= '0;
            pending  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state   <= next_state;
            pending <= pending_next;
            done_q  <= final_hs;
            if (load_frame) begin
                snapshot <= display;
                byte_idx <= '0;
            end else if (advance) begin
                byte_idx <= byte_idx + SCAN_IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_chip8_display_scanout.sv
// Directed bench for chip8_display_scanout (default refresh, request-driven).
`timescale 1ns/1ps
module tb_chip8_display_scanout;

`ifdef CHIP8_SCANOUT_SCALE2X_EN
    localparam int NB = 1024;
    localparam int NZ = 2;
    localparam int A0 = 266, A1 = 267;  localparam logic [7:0] AV = 8'h30;  // pixel (5,10)
    localparam int O0 = 0,   O1 = 1;    localparam logic [7:0] OV = 8'h03;  // pixel (0,0)
    localparam int C0 = 1022, C1 = 1023; localparam logic [7:0] CV = 8'hC0; // pixel (63,31)
`else
    localparam int NB = 256;
    localparam int NZ = 1;
    localparam int A0 = 69,  A1 = 69;   localparam logic [7:0] AV = 8'h04;
    localparam int O0 = 0,   O1 = 0;    localparam logic [7:0] OV = 8'h01;
    localparam int C0 = 255, C1 = 255;  localparam logic [7:0] CV = 8'h80;
`endif

    logic          clk;
    logic          reset;
    logic [2047:0] display;
    logic          frame_req;
    logic          out_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_last;
    logic          busy;
    logic          frame_done;

    chip8_display_scanout dut (
        .clk        (clk),
        .reset      (reset),
        .display    (display),
        .frame_req  (frame_req),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         nvec  = 0;
    int         nfail = 0;
    logic [7:0] got [0:2*NB-1];
    int         nb, nlast, ndone, nvalid, first_valid;
    int         stall_bad, busy_bad, last_bad;
    int         last_pos [0:3];
    int         done_at  [0:3];

    function automatic logic [2047:0] px(input int x, input int y);
        logic [2047:0] v;
        v = '0;
        v[y*64 + x] = 1'b1;
        return v;
    endfunction

    function automatic int count_nz(input int from, input int n);
        int c = 0;
        for (int i = from; i < from + n; i++) if (got[i] != 8'h00) c++;
        return c;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Issue a one-edge frame request starting from a post-edge sample point.
    task automatic request;
        @(posedge clk); #1;
        frame_req = 1'b1;
    endtask

    // Run a bounded number of cycles, logging accepted bytes and control events.
    task automatic run(input int cycles, input bit rnd, input int trig_at,
                       input bit trig_req, input logic [2047:0] disp_after);
        bit         had_stall = 1'b0;
        logic [7:0] held_d = 8'h00;
        logic       held_l = 1'b0;
        nb = 0; nlast = 0; ndone = 0; nvalid = 0; first_valid = -1;
        stall_bad = 0; busy_bad = 0; last_bad = 0;
        for (int i = 0; i < 4; i++) begin last_pos[i] = -1; done_at[i] = -1; end
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            frame_req = 1'b0;
            if (frame_done) begin
                if (ndone < 4) done_at[ndone] = nb;
                ndone++;
            end
            if (out_valid) begin
                nvalid++;
                if (first_valid < 0) first_valid = c;
            end
            if (busy !== out_valid) busy_bad++;
            if (out_last && !out_valid) last_bad++;
            if (had_stall && (!out_valid || out_data !== held_d || out_last !== held_l)) stall_bad++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                if (nb < 2*NB) got[nb] = out_data;
                if (out_last) begin
                    if (nlast < 4) last_pos[nlast] = nb;
                    nlast++;
                end
                nb++;
                if (nb == trig_at) begin
                    display   = disp_after;
                    frame_req = trig_req;
                end
            end
            had_stall = out_valid && !out_ready;
            held_d    = out_data;
            held_l    = out_last;
        end
    endtask

    initial begin
        reset = 1'b0; display = '0; frame_req = 1'b0; out_ready = 1'b0;

        // Reset held: everything quiet.
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_last",  int'(out_last), 0);
        check("rst_done",  int'(frame_done), 0);
        check("rst_data",  int'(out_data), 0);

        // Released with no request: nothing for 100 cycles.
        @(negedge clk) reset = 1'b1;
        run(100, 1'b0, -1, 1'b0, '0);
        check("idle_bytes", nb, 0);
        check("idle_done",  ndone, 0);
        check("idle_valid", first_valid, -1);

        // All-zero frame with out_ready held high.
        display = '0;
        request();
        run(NB + 40, 1'b0, -1, 1'b0, '0);
        check("zero_bytes",     nb, NB);
        check("zero_latency",   first_valid, 0);
        check("zero_nvalid",    nvalid, NB);
        check("zero_nonzero",   count_nz(0, NB), 0);
        check("zero_nlast",     nlast, 1);
        check("zero_last_pos",  last_pos[0], NB - 1);
        check("zero_ndone",     ndone, 1);
        check("zero_done_at",   done_at[0], NB);
        check("zero_busy",      busy_bad, 0);
        check("zero_last_bad",  last_bad, 0);

        // Single pixel (5,10).
        display = px(5, 10);
        request();
        run(NB + 40, 1'b0, -1, 1'b0, '0);
        check("px_bytes",   nb, NB);
        check("px_nonzero", count_nz(0, NB), NZ);
        check("px_byte_a0", int'(got[A0]), int'(AV));
        check("px_byte_a1", int'(got[A1]), int'(AV));

        // Corners lit, random stalls, display cleared after byte 10.
        display = px(0, 0) | px(63, 31);
        request();
        run(2*NB + 200, 1'b1, 10, 1'b0, '0);
        check("stall_bytes",    nb, NB);
        check("stall_stable",   stall_bad, 0);
        check("stall_origin0",  int'(got[O0]), int'(OV));
        check("stall_origin1",  int'(got[O1]), int'(OV));
        check("stall_corner0",  int'(got[C0]), int'(CV));
        check("stall_corner1",  int'(got[C1]), int'(CV));
        check("stall_nonzero",  count_nz(0, NB), 2*NZ);
        check("stall_nlast",    nlast, 1);
        check("stall_last_pos", last_pos[0], NB - 1);
        check("stall_ndone",    ndone, 1);

        // Request queued at byte 100; second frame follows with no gap and new content.
        display = px(5, 10);
        request();
        run(2*NB + 40, 1'b0, 100, 1'b1, px(0, 0));
        check("b2b_bytes",     nb, 2*NB);
        check("b2b_nvalid",    nvalid, 2*NB);
        check("b2b_nlast",     nlast, 2);
        check("b2b_last0",     last_pos[0], NB - 1);
        check("b2b_last1",     last_pos[1], 2*NB - 1);
        check("b2b_ndone",     ndone, 2);
        check("b2b_done0",     done_at[0], NB);
        check("b2b_done1",     done_at[1], 2*NB);
        check("b2b_f1_pixel",  int'(got[A0]), int'(AV));
        check("b2b_f2_origin", int'(got[NB + O0]), int'(OV));
        check("b2b_f2_old",    int'(got[NB + A0]), 0);
        check("b2b_f2_nz",     count_nz(NB, NB), NZ);

        // Reset mid-frame aborts at once and produces no completion.
        display = px(0, 0);
        request();
        run(20, 1'b0, -1, 1'b0, '0);
        check("abort_pre_bytes", nb, 20);
        #2 reset = 1'b0;
        #1;
        check("abort_valid", int'(out_valid), 0);
        check("abort_busy",  int'(busy), 0);
        check("abort_last",  int'(out_last), 0);
        check("abort_done",  int'(frame_done), 0);
        @(negedge clk) reset = 1'b1;
        run(50, 1'b0, -1, 1'b0, '0);
        check("abort_bytes", nb, 0);
        check("abort_ndone", ndone, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
